// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encodings,
// iteration counts and default operand width.
package mult_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MULT_STEPS    = 32;
    localparam int DIV_STEPS     = 32;

`ifdef MULTDIV_UNSIGNED_EN
    // Unsigned multiply runs one extra Booth step, so the counter needs to reach 32.
    localparam int CNT_W = 6;
`else
    localparam int CNT_W = 5;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_DIV  = 2'd1,
        OP_DZ   = 2'd2
    } op_t;

endpackage

// File: rtl/mult_div_unit_div.sv
// div_core: restoring divider on operand magnitudes, one quotient bit per step,
// with sign correction applied combinationally on the outputs.
module div_core
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             uns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q;
    logic             neg_r;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    assign a_neg = !uns && a[WIDTH-1];
    assign b_neg = !uns && b[WIDTH-1];

    // Remainder stays below the divisor, so the W+1-bit trial difference cannot overflow.
    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_r};
    assign fits    = !diff[WIDTH];

    always_ff @(posedge clk) begin
        if (load) begin
            rem_r <= '0;
            quo_r <= cond_neg(a, a_neg);
            dvs_r <= cond_neg(b, b_neg);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (step) begin
            rem_r <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], fits};
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quot = cond_neg(quo_r, neg_q);
    assign rem  = cond_neg(rem_r, neg_r);

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit producing HI/LO: radix-2 Booth multiplier plus
// restoring divider (div_core). Optional MULTDIV_UNSIGNED_EN adds op_unsigned.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);

    function automatic logic signed [WIDTH+1:0] booth_add(
        input logic signed [WIDTH+1:0] acc_v,
        input logic signed [WIDTH+1:0] m_v,
        input logic [1:0]              pair
    );
        case (pair)
            2'b01:   return acc_v + m_v;
            2'b10:   return acc_v - m_v;
            default: return acc_v;
        endcase
    endfunction

    state_t                   state;
    state_t                   state_n;
    op_t                      op_r;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         mult_last;
    logic                     accept_mult;
    logic                     accept_div;
    logic                     accept_dz;
    logic                     mult_step;
    logic                     div_step;
    logic                     fin;
    logic                     uns_in;
    logic                     uns_r;
    logic signed [WIDTH+1:0]  acc;
    logic signed [WIDTH+1:0]  mcand;
    logic signed [WIDTH+1:0]  booth_sum;
    logic [WIDTH:0]           mq;
    logic                     qm1;
    logic [WIDTH-1:0]         quot;
    logic [WIDTH-1:0]         rem;
    logic [WIDTH-1:0]         res_hi;
    logic [WIDTH-1:0]         res_lo;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in    = op_unsigned;
    assign mult_last = uns_r ? CNT_W'(MULT_STEPS) : CNT_W'(MULT_STEPS - 1);
`else
    assign uns_in    = 1'b0;
    assign mult_last = CNT_W'(MULT_STEPS - 1);
`endif

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_n     = state;
        accept_mult = 1'b0;
        accept_div  = 1'b0;
        accept_dz   = 1'b0;
        mult_step   = 1'b0;
        div_step    = 1'b0;
        fin         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_mult) begin
                    accept_mult = 1'b1;
                    state_n     = ST_MULT;
                end else if (start_div) begin
                    if (b == '0) begin
                        accept_dz = 1'b1;
                        state_n   = ST_FINISH;
                    end else begin
                        accept_div = 1'b1;
                        state_n    = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                mult_step = 1'b1;
                if (cnt == mult_last) state_n = ST_FINISH;
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt == DIV_LAST) state_n = ST_FINISH;
            end
            ST_FINISH: begin
                fin     = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_r     <= OP_MULT;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_n;
            done  <= fin;
            if (accept_mult || accept_div || accept_dz)
                cnt <= '0;
            else if (mult_step || div_step)
                cnt <= cnt + 1'b1;
            if (accept_mult)
                op_r <= OP_MULT;
            else if (accept_div)
                op_r <= OP_DIV;
            else if (accept_dz)
                op_r <= OP_DZ;
            if (accept_mult || accept_div)
                div_zero <= 1'b0;
            else if (accept_dz)
                div_zero <= 1'b1;
            // A divide-by-zero leaves the previous HI/LO in place.
            if (fin && op_r != OP_DZ) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign booth_sum = booth_add(acc, mcand, {mq[0], qm1});

    // Operands get one extra guard bit so the signed minimum and the unsigned
    // maximum both survive the Booth subtract without overflow.
    always_ff @(posedge clk) begin
        if (accept_mult || accept_div)
            uns_r <= uns_in;
        if (accept_mult) begin
            acc   <= '0;
            mcand <= uns_in ? $signed({2'b00, a}) : $signed({{2{a[WIDTH-1]}}, a});
            mq    <= {(!uns_in && b[WIDTH-1]), b};
            qm1   <= 1'b0;
        end else if (mult_step) begin
            acc <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
            mq  <= {booth_sum[0], mq[WIDTH:1]};
            qm1 <= mq[0];
        end
    end

    // Signed runs W steps, leaving the product one bit higher than the W+1-step unsigned run.
    always_comb begin
        res_hi = quot;
        res_lo = quot;
        if (op_r == OP_DIV) begin
            res_hi = rem;
            res_lo = quot;
        end else if (uns_r) begin
            res_hi = {acc[WIDTH-2:0], mq[WIDTH]};
            res_lo = mq[WIDTH-1:0];
        end else begin
            res_hi = acc[WIDTH-1:0];
            res_lo = mq[WIDTH:1];
        end
    end

    div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk  (clk),
        .load (accept_div),
        .step (div_step),
        .uns  (uns_r),
        .a    (a),
        .b    (b),
        .quot (quot),
        .rem  (rem)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero/latency,
// an independent monitor pops and checks on every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;
`ifdef MULTDIV_UNSIGNED_EN
    logic        op_unsigned = 1'b0;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          acc_cyc;
        string       nm;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
        end
    endtask

    // Monitor: count edges, stamp newly accepted ops, check on done, watch busy.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < sbq.size(); i++)
            if (sbq[i].acc_cyc < 0) sbq[i].acc_cyc = cyc;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check32({e.nm, "_hi"}, hi, e.hi);
                check32({e.nm, "_lo"}, lo, e.lo);
                check32({e.nm, "_divzero"}, 32'(div_zero), 32'(e.dz));
                check32({e.nm, "_latency"}, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
                check32({e.nm, "_busy_at_done"}, 32'(busy), 32'h0);
            end
        end else if (sbq.size() != 0 && sbq[0].acc_cyc >= 0) begin
            check32({sbq[0].nm, "_busy"}, 32'(busy), 32'h1);
        end
    end

    // Reference model: 64-bit arithmetic straight from the operation definitions.
    task automatic build_exp(input int kind, input logic [31:0] av, input logic [31:0] bv,
                             input string nm, output exp_t e);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        longint      q;
        longint      r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        e.nm = nm;
        e.acc_cyc = -1;
        e.dz = 1'b0;
        e.lat = 34;
        if (kind != 1) begin
            p = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (bv == 32'h0) begin
            e.dz = 1'b1;
            e.lat = 2;
            e.hi = m_hi;
            e.lo = m_lo;
        end else begin
            q = sa / sb;
            r = sa % sb;
            p = 64'(q);
            e.lo = p[31:0];
            p = 64'(r);
            e.hi = p[31:0];
        end
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // kind: 0 = multiply, 1 = divide, 2 = both starts together
    task automatic issue(input int kind, input logic [31:0] av, input logic [31:0] bv,
                         input string nm);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait actual=busy required=idle", nm);
            return;
        end
        build_exp(kind, av, bv, nm, e);
        a = av;
        b = bv;
        start_mult = (kind != 1);
        start_div  = (kind != 0);
        @(posedge clk);
        sbq.push_back(e);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        check32({nm, "_divzero_after_accept"}, 32'(div_zero), 32'(e.dz));
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain actual=%0d pending required=0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (3) @(negedge clk);
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        check32("reset_busy", 32'(busy), 32'h0);
        check32("reset_done", 32'(done), 32'h0);
        check32("reset_divzero", 32'(div_zero), 32'h0);
        reset = 1'b0;

        issue(0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        issue(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "mul_maxpos");
        issue(0, 32'h8000_0000, 32'h8000_0000, "mul_minneg");
        issue(1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        issue(1, 32'h0000_0451, 32'h0000_0020, "div_prior");
        issue(1, 32'd5, 32'd0, "div_zero");
        issue(0, 32'd3, 32'd4, "mul_clears_dz");

        // A divide request during a running multiply must be dropped.
        issue(0, 32'h1234_5678, 32'hFEDC_BA98, "mul_with_stray_div");
        repeat (9) @(negedge clk);
        start_div = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start_div = 1'b0;
        issue(2, 32'hFFFF_FF00, 32'd300, "both_starts");
        wait_idle("directed");

        // Reset in the middle of a divide aborts without a done pulse.
        issue(1, 32'hFFFF_FF9C, 32'd7, "div_aborted");
        repeat (14) @(negedge clk);
        sbq.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("abort_busy", 32'(busy), 32'h0);
        check32("abort_hi", hi, 32'h0);
        check32("abort_lo", lo, 32'h0);
        check32("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        repeat (40) @(negedge clk);
        issue(0, 32'hFFFF_FFF6, 32'd11, "mul_after_reset");

        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] av;
            logic [31:0] bv;
            k  = $urandom_range(0, 1);
            av = pick();
            bv = pick();
            if (k == 1 && $urandom_range(0, 7) == 0) bv = 32'h0;
            issue(k, av, bv, (k == 0) ? "rand_mul" : "rand_div");
        end
        wait_idle("random");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
